// File: rtl/interp_transpose_buffer_pkg.sv
// Shared constants and types for the separable interpolation datapath.
package interp_transpose_buffer_pkg;

    localparam int N        = 11;
    localparam int SAMPLE_W = 9;
    localparam int W        = N * SAMPLE_W;
    localparam int CNT_W    = $clog2(N);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    typedef logic [CNT_W-1:0] cnt_t;

    // Whole block as mem[row][col] of raw sample bits.
    typedef logic [N-1:0][N-1:0][SAMPLE_W-1:0] block_t;

    // True when a row or column counter sits on the last index of the block.
    function automatic logic is_last(input cnt_t c);
        return c == cnt_t'(N - 1);
    endfunction

endpackage

// File: rtl/interp_transpose_buffer_col_extract.sv
// Picks one column out of the stored block and packs it with row 0 in the LSBs.
module interp_col_extract
    import interp_transpose_buffer_pkg::*;
(
    input  logic              [CNT_W-1:0] col_idx,
    input  block_t                        mem,
    output logic signed       [W-1:0]     col
);

    // Gather sample [r][col_idx] of every row; an out-of-range index yields zero.
    always_comb begin
        col = '0;
        if (col_idx < cnt_t'(N)) begin
            for (int r = 0; r < N; r++) begin
                col[r*SAMPLE_W +: SAMPLE_W] = mem[r][col_idx];
            end
        end
    end

endmodule

// File: rtl/interp_transpose_buffer.sv
// Single-bank row-to-column transpose buffer: fills N lines, then replays N columns.
module interp_transpose_buffer
    import interp_transpose_buffer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [W-1:0]  line_in,
    input  logic                 line_valid,
    output logic                 line_ready,
    output logic signed [W-1:0]  col_out,
    output logic                 col_valid,
    input  logic                 col_ready,
    output logic                 block_done
);

    state_t state;
    cnt_t   row_cnt;
    cnt_t   col_cnt;
    block_t mem;
    logic   line_fire;
    logic   col_fire;

    assign line_fire = line_valid & line_ready;
    assign col_fire  = col_valid & col_ready;

    // Store an accepted line into the row selected by row_cnt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '0;
        end else if (line_fire) begin
            mem[row_cnt] <= line_in;
        end
    end

    // Fill/drain sequencer with registered handshake outputs and done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FILL;
            row_cnt    <= '0;
            col_cnt    <= '0;
            line_ready <= 1'b0;
            col_valid  <= 1'b0;
            block_done <= 1'b0;
        end else begin
            block_done <= 1'b0;
            case (state)
                FILL: begin
                    line_ready <= 1'b1;
                    if (line_fire) begin
                        if (is_last(row_cnt)) begin
                            row_cnt    <= '0;
                            state      <= DRAIN;
                            line_ready <= 1'b0;
                            col_valid  <= 1'b1;
                        end else begin
                            row_cnt <= row_cnt + cnt_t'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (col_fire) begin
                        if (is_last(col_cnt)) begin
                            col_cnt    <= '0;
                            state      <= FILL;
                            col_valid  <= 1'b0;
                            line_ready <= 1'b1;
                            block_done <= 1'b1;
                        end else begin
                            col_cnt <= col_cnt + cnt_t'(1);
                        end
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

    interp_col_extract u_col_extract (
        .col_idx (col_cnt),
        .mem     (mem),
        .col     (col_out)
    );

endmodule
